rr_hold_arb: RTL and testbench
==============================

Name: rr_hold_arb

Overview:
- Sequential round-robin arbiter with grant locking.
- It shares one resource among N requesters by driving a rotating one-hot priority into the existing combinational fixed_prior_arb_give pick stage.
- It registers the winner and holds the grant until the owner releases, a hold timeout expires, or the block is disabled.
- It sits between requester agents and the shared resource and is the sequencing layer above the fixed-priority picker.

Parameters:
N, 4, number of requesters (N >= 2)
MAX_HOLD, 8, maximum consecutive grant cycles per owner; 0 = unlimited (no preemption)
ID_W, $clog2(N), width of gnt_id
CNT_W, $clog2(MAX_HOLD+1) (min 1), width of hold counter

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  arbitration enable
req  input  N  level request per requester; held high while the resource is wanted
gnt  output  N  registered one-hot grant; 0 when no owner
gnt_id  output  ID_W  binary index of owner; 0 when valid=0
valid  output  1  high while a grant is held (= |gnt)
preempt  output  1  one-cycle pulse when the owner loses the grant by timeout
prio_ptr  output  N  current one-hot priority (highest-priority position), for observation

Behaviour:
- Reset (async, any time, including mid-grant):
  - gnt=0, gnt_id=0, valid=0, preempt=0, prio_ptr=1 (bit 0), hold_cnt=0, state=IDLE.
  - On deassertion the first decision occurs on the next rising edge.
- Pick function: fixed_prior_arb_give(req, enable=en, priority=prio_ptr).
  - Searches from the prio_ptr position upward, wrapping modulo N.
  - Returns the first set req bit and valid.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and |req=1: next edge gnt=pick result, gnt_id=its index, valid=1, hold_cnt=1, go to GRANT.
  - Latency is 1 cycle from req to gnt.
  - Otherwise outputs stay 0.
- GRANT, evaluated each edge, first match wins:
  - en=0 (abort): gnt=0, valid=0, go to IDLE. prio_ptr unchanged.
  - req[gnt_id]=0 (release): gnt=0, go to IDLE. prio_ptr = gnt rotated left by 1, with bit N-1 wrapping to bit 0.
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD (timeout): gnt=0, preempt=1 for exactly this cycle, prio_ptr rotated as for release, go to IDLE.
  - Otherwise: hold gnt; hold_cnt increments (saturates at MAX_HOLD, no wrap).
- Every ownership change passes through one IDLE cycle with gnt=0 (dead cycle). Back-to-back grants are therefore at least 1 idle cycle apart.
- After a timeout, an owner still requesting becomes lowest priority. It regains the grant only if no other requester is active.
- Grant stability: gnt changes only on an edge, never while the owner holds req high within the hold limit.
- Non-owner req toggling during GRANT has no effect.
- Invariants:
  - gnt is 0 or one-hot.
  - gnt is a subset of the req sampled at grant time.
  - prio_ptr is always one-hot.
  - preempt is never high together with valid.
- MAX_HOLD=0: hold_cnt is held at 0 and preempt never asserts.

Decomposition:
- Shared package: state encoding (IDLE=0, GRANT=1) and a one-hot-to-index function used for gnt_id and by the bench.
- Sub-module: fixed_prior_arb_give instantiated once as the pick stage; no other sub-modules.
- Rotation, counter and FSM live in rr_hold_arb.

Test Plan:
1. Reset mid-grant: N=4, req=4'b0100 granted, assert rst -> gnt=0, valid=0, prio_ptr=4'b0001 immediately (async); after release, req=4'b1111 -> gnt=4'b0001.
2. Rotation: req=4'b1111 held, each owner drops req 3 cycles after grant and reasserts 1 cycle later -> grant order 0001,0010,0100,1000,0001 with one gnt=0 cycle between each; prio_ptr follows 0010,0100,1000,0001.
3. Timeout: MAX_HOLD=8, req=4'b0011 held constant -> gnt=0001 for 8 cycles, then preempt pulse with gnt=0, then gnt=0010 for 8 cycles, alternating; preempt high only in the gap cycles.
4. Sole requester timeout: req=4'b1000 only, MAX_HOLD=8 -> 8 cycles granted, 1 gap with preempt=1, re-granted 1000; prio_ptr=0001 after the first timeout.
5. Abort: owner 2 (gnt=0100), en dropped for 2 cycles -> gnt=0 next edge, prio_ptr unchanged (0100); en=1 with req=4'b0110 -> gnt=0100 again.
6. Exhaustive: all 16 req values x 4 prio_ptr values from IDLE, MAX_HOLD=0 -> first grant equals the fixed-priority model; gnt_id matches index; never a grant with req=0.

Source files
------------

// File: rtl/rr_hold_arb_pkg.sv
// Shared definitions for the round-robin hold arbiter.
//   arb_state_e : FSM state encoding (StIdle = 0, StGrant = 1)
//   onehot_idx  : binary index of the set bit in a one-hot vector (0 for an all-zero vector)
package rr_hold_arb_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    // OR-accumulating the indices avoids a priority chain; valid only for 0 or one-hot input.
    function automatic int unsigned onehot_idx(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = idx | 32'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fixed_prior_arb_give.sv
// Combinational fixed-priority picker with a movable priority point.
// Searches req starting at the one-hot prio position upward, wrapping modulo N,
// and returns the first set bit.
//   req    : request vector
//   enable : gate; no grant when low
//   prio   : one-hot position that has highest priority
//   gnt    : one-hot pick, 0 when nothing is picked
//   valid  : high when gnt is non-zero
module fixed_prior_arb_give #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic         enable,
    input  logic [N-1:0] prio,
    output logic [N-1:0] gnt,
    output logic         valid
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;

    // Doubling req turns the wrap-around search into a plain borrow chain: subtracting prio
    // clears the lowest set bit at or above prio, and masking leaves exactly that bit.
    assign req_dbl = {req, req};
    assign gnt_dbl = req_dbl & ~(req_dbl - {{N{1'b0}}, prio});

    always_comb begin
        gnt = '0;
        if (enable) begin
            gnt = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
        end
    end

    assign valid = |gnt;

endmodule

// File: rtl/rr_hold_arb.sv
// Round-robin arbiter with grant locking. Registers the winner of the fixed-priority pick
// stage and holds the grant until the owner drops req, the hold limit expires, or en falls.
// Each ownership change passes through one idle cycle with gnt = 0.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : arbitration enable; dropping it aborts the current grant
//   req      : level requests
//   gnt      : registered one-hot grant
//   gnt_id   : binary index of the owner, 0 when no owner
//   valid    : a grant is held
//   preempt  : one-cycle pulse in the gap after a hold timeout
//   prio_ptr : one-hot highest-priority position
module rr_hold_arb
    import rr_hold_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(N),
    parameter int CNT_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            valid,
    output logic            preempt,
    output logic [N-1:0]    prio_ptr
);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [N-1:0]     prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preempt_q, preempt_d;

    logic [N-1:0]     pick_gnt;
    logic             pick_valid;
    logic [N-1:0]     gnt_rot;
    logic             hold_expired;

    fixed_prior_arb_give #(
        .N (N)
    ) u_pick (
        .req    (req),
        .enable (en),
        .prio   (prio_q),
        .gnt    (pick_gnt),
        .valid  (pick_valid)
    );

    // The position just above the outgoing owner becomes highest priority.
    assign gnt_rot      = {gnt_q[N-2:0], gnt_q[N-1]};
    assign hold_expired = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                gnt_d = '0;
                id_d  = '0;
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = StGrant;
                    gnt_d   = pick_gnt;
                    id_d    = ID_W'(onehot_idx(32'(pick_gnt)));
                    cnt_d   = (MAX_HOLD == 0) ? '0 : CNT_W'(1);
                end
            end
            StGrant: begin
                if (!en) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    id_d    = '0;
                    cnt_d   = '0;
                end else if (!req[id_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    id_d    = '0;
                    cnt_d   = '0;
                    prio_d  = gnt_rot;
                end else if (hold_expired) begin
                    state_d   = StIdle;
                    gnt_d     = '0;
                    id_d      = '0;
                    cnt_d     = '0;
                    prio_d    = gnt_rot;
                    preempt_d = 1'b1;
                end else if (MAX_HOLD != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                id_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            id_q      <= '0;
            prio_q    <= {{(N-1){1'b0}}, 1'b1};
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = id_q;
    assign valid    = |gnt_q;
    assign preempt  = preempt_q;
    assign prio_ptr = prio_q;

endmodule

// File: tb/tb_rr_hold_arb.sv
// Bench for rr_hold_arb: two instances (hold limit 8 and unlimited) share the stimulus.
// The driver advances an index-based reference model per instance and queues the expected
// outputs; the monitor pops and compares one entry per instance after every rising edge.
module tb_rr_hold_arb;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [N-1:0] req = '0;

    logic [N-1:0] gnt8, gnt0;
    logic [1:0]   id8, id0;
    logic         val8, val0, pre8, pre0;
    logic [N-1:0] prio8, prio0;

    rr_hold_arb #(.N(N), .MAX_HOLD(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .req(req), .gnt(gnt8), .gnt_id(id8),
        .valid(val8), .preempt(pre8), .prio_ptr(prio8)
    );

    rr_hold_arb #(.N(N), .MAX_HOLD(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .req(req), .gnt(gnt0), .gnt_id(id0),
        .valid(val0), .preempt(pre0), .prio_ptr(prio0)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    // Expected vector layout: {gnt[3:0], gnt_id[1:0], valid, preempt, prio_ptr[3:0]}
    logic [11:0] q8[$];
    logic [11:0] q0[$];

    // Reference model state, index [0] = hold limit 8, [1] = unlimited.
    int m_owner[2];
    int m_prio[2];
    int m_hold[2];
    bit m_pre[2];
    int m_max[2] = '{8, 0};

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_prio[k]  = 0;
            m_hold[k]  = 0;
            m_pre[k]   = 1'b0;
        end
    endfunction

    function automatic void model_step(input int k, input logic [N-1:0] r, input logic e);
        m_pre[k] = 1'b0;
        if (m_owner[k] < 0) begin
            if (e && (r != 0)) begin
                for (int o = 0; o < N; o++) begin
                    int i;
                    i = (m_prio[k] + o) % N;
                    if (r[i] && m_owner[k] < 0) m_owner[k] = i;
                end
                m_hold[k] = (m_max[k] == 0) ? 0 : 1;
            end
        end else if (!e) begin
            m_owner[k] = -1;
        end else if (!r[m_owner[k]]) begin
            m_prio[k]  = (m_owner[k] + 1) % N;
            m_owner[k] = -1;
        end else if (m_max[k] != 0 && m_hold[k] == m_max[k]) begin
            m_prio[k]  = (m_owner[k] + 1) % N;
            m_owner[k] = -1;
            m_pre[k]   = 1'b1;
        end else if (m_max[k] != 0) begin
            m_hold[k] = m_hold[k] + 1;
        end
    endfunction

    function automatic logic [11:0] model_vec(input int k);
        logic [3:0] g;
        logic [1:0] id;
        logic [3:0] p;
        g  = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0000;
        id = (m_owner[k] >= 0) ? 2'(m_owner[k]) : 2'd0;
        p  = 4'(1 << m_prio[k]);
        return {g, id, (m_owner[k] >= 0), m_pre[k], p};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got gnt=%b id=%0d valid=%b preempt=%b prio=%b, expected gnt=%b id=%0d valid=%b preempt=%b prio=%b",
                     name, $time, act[11:8], act[7:6], act[5], act[4], act[3:0],
                     exp[11:8], exp[7:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, queue the post-edge expectation.
    task automatic cycle(input logic [N-1:0] r, input logic e);
        @(negedge clk);
        rst = 1'b0;
        req = r;
        en  = e;
        for (int k = 0; k < 2; k++) model_step(k, r, e);
        q8.push_back(model_vec(0));
        q0.push_back(model_vec(1));
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        logic [11:0] rst_exp;
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst_exp = 12'b0000_00_0_0_0001;
        check("async_reset_h8", {gnt8, id8, val8, pre8, prio8}, rst_exp);
        check("async_reset_h0", {gnt0, id0, val0, pre0, prio0}, rst_exp);
        model_reset();
        q8.delete();
        q0.delete();
        q8.push_back(model_vec(0));
        q0.push_back(model_vec(1));
        started = 1'b1;
    endtask

    // Monitor: one queued expectation per instance per rising edge.
    always begin
        @(posedge clk);
        #1;
        if (started) begin
            if (q8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow_h8 at %0t: no expected entry queued", $time);
            end else begin
                check("cycle_h8", {gnt8, id8, val8, pre8, prio8}, q8.pop_front());
            end
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow_h0 at %0t: no expected entry queued", $time);
            end else begin
                check("cycle_h0", {gnt0, id0, val0, pre0, prio0}, q0.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        logic         e;

        repeat (2) @(posedge clk);

        // Reset mid-grant, then all-request restart from position 0.
        do_reset();
        repeat (3) cycle(4'b0100, 1'b1);
        do_reset();
        cycle(4'b0000, 1'b1);
        repeat (3) cycle(4'b1111, 1'b1);

        // Rotation: owner drops req on its 4th grant cycle for one cycle.
        do_reset();
        for (int c = 0; c < 30; c++) begin
            r = 4'b1111;
            if (m_owner[0] >= 0 && m_hold[0] == 3) r[m_owner[0]] = 1'b0;
            cycle(r, 1'b1);
        end

        // Timeout alternation between two constant requesters.
        do_reset();
        repeat (40) cycle(4'b0011, 1'b1);

        // Sole requester timeout and re-grant.
        do_reset();
        repeat (25) cycle(4'b1000, 1'b1);

        // Abort keeps the priority pointer.
        do_reset();
        repeat (2) cycle(4'b0010, 1'b1);
        cycle(4'b0000, 1'b1);
        repeat (2) cycle(4'b0100, 1'b1);
        repeat (2) cycle(4'b0100, 1'b0);
        repeat (3) cycle(4'b0110, 1'b1);

        // Every request pattern from IDLE at every priority position.
        for (int p = 0; p < N; p++) begin
            for (int v = 0; v < 16; v++) begin
                do_reset();
                if (p > 0) begin
                    cycle(4'(1 << (p - 1)), 1'b1);
                    cycle(4'b0000, 1'b1);
                end
                cycle(4'(v), 1'b1);
                cycle(4'(v), 1'b1);
            end
        end

        // Randomized traffic with sticky requests so hold limits are reached.
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(r, e);
        end

        @(posedge clk);
        #2;
        started = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
